// File: rtl/floppy_pkg.sv
// rtl/floppy_pkg.sv - shared state encoding, widths and byte-lane helper for the floppy SDRAM port
package floppy_pkg;

  localparam int FADDR_W = 23;
  localparam int MADDR_W = 22;
  localparam int MDATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // Pick the addressed byte out of an SDRAM word; hi=1 selects bits [15:8].
  function automatic logic [7:0] byte_sel(input logic [MDATA_W-1:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/floppy_sdram_rdcache.sv
// rtl/floppy_sdram_rdcache.sv - one-word read cache (tag, data, valid) used when FLOPPY_SDRAM_RDCACHE_EN is defined
module floppy_sdram_rdcache
  import floppy_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               inv_i,
  input  logic [MADDR_W-1:0] lookup_addr_i,
  output logic               hit_o,
  output logic [MDATA_W-1:0] word_o,
  input  logic               fill_i,
  input  logic [MADDR_W-1:0] fill_addr_i,
  input  logic [MDATA_W-1:0] fill_data_i,
  input  logic               wr_i,
  input  logic [MADDR_W-1:0] wr_addr_i,
  input  logic               wr_hi_i,
  input  logic [7:0]         wr_byte_i
);

  logic               valid_q;
  logic [MADDR_W-1:0] tag_q;
  logic [MDATA_W-1:0] word_q;

  assign hit_o  = valid_q && (tag_q == lookup_addr_i);
  assign word_o = word_q;

  // Fill on read data, patch the cached byte on a matching write, invalidate beats fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else begin
      if (fill_i) begin
        tag_q  <= fill_addr_i;
        word_q <= fill_data_i;
      end
      if (wr_i && valid_q && (tag_q == wr_addr_i)) begin
        if (wr_hi_i) word_q[15:8] <= wr_byte_i;
        else         word_q[7:0]  <= wr_byte_i;
      end
      if (inv_i)       valid_q <= 1'b0;
      else if (fill_i) valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/floppy_sdram_port.sv
// rtl/floppy_sdram_port.sv - floppy byte port onto a 16-bit SDRAM arbiter; FLOPPY_SDRAM_RDCACHE_EN adds a one-word read cache
module floppy_sdram_port
  import floppy_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [FADDR_W-1:0] f_addr,
  input  logic [7:0]         f_wdata,
  input  logic               f_read,
  input  logic               f_write,
  output logic [7:0]         f_rdata,
  output logic               f_busy,
  input  logic               cache_inv,
  output logic [MADDR_W-1:0] mem_addr,
  output logic [MDATA_W-1:0] mem_wdata,
  output logic [1:0]         mem_be,
  output logic               mem_req,
  output logic               mem_we,
  input  logic               mem_ack,
  input  logic [MDATA_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  output logic               overrun
);

  state_t             state_q, state_d;
  logic [FADDR_W-1:0] addr_q;
  logic [7:0]         wdata_q;
  logic               we_q;
  logic [1:0]         be_q;
  logic [7:0]         rdata_q;
  logic               overrun_q;

  logic               idle;
  logic               accept;
  logic               accept_wr;
  logic               hit_rd;
  logic               rd_load;
  logic               cache_hit;
  logic [MDATA_W-1:0] cache_word;

  assign idle      = (state_q == ST_IDLE);
  assign accept    = idle && (f_read || f_write);
  assign accept_wr = accept && f_write;
  assign hit_rd    = accept && !f_write && cache_hit;
  // Read data is taken only for an outstanding read: with its ack, or while waiting for it.
  assign rd_load   = ((state_q == ST_REQ) && mem_ack && !we_q && mem_rvalid) ||
                     ((state_q == ST_WAIT_DATA) && mem_rvalid);

`ifdef FLOPPY_SDRAM_RDCACHE_EN
  floppy_sdram_rdcache u_rdcache (
    .clk           (clk),
    .reset_n       (reset_n),
    .inv_i         (cache_inv),
    .lookup_addr_i (f_addr[FADDR_W-1:1]),
    .hit_o         (cache_hit),
    .word_o        (cache_word),
    .fill_i        (rd_load),
    .fill_addr_i   (addr_q[FADDR_W-1:1]),
    .fill_data_i   (mem_rdata),
    .wr_i          (accept_wr),
    .wr_addr_i     (f_addr[FADDR_W-1:1]),
    .wr_hi_i       (f_addr[0]),
    .wr_byte_i     (f_wdata)
  );
`else
  logic unused_cache_inv;
  assign unused_cache_inv = cache_inv ^ accept_wr;
  assign cache_hit        = 1'b0;
  assign cache_word       = '0;
`endif

  // State register; reset aborts any transaction at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state: write wins over read, cache hits skip the SDRAM entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (f_write)                   state_d = ST_REQ;
        else if (f_read && cache_hit)  state_d = ST_DONE;
        else if (f_read)               state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (we_q || mem_rvalid) state_d = ST_DONE;
          else                    state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (mem_rvalid) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so reset removes mem_req and f_busy without waiting for a clock.
  always_comb begin
    f_busy  = 1'b0;
    mem_req = 1'b0;
    f_busy  = (state_q != ST_IDLE);
    mem_req = (state_q == ST_REQ);
  end

  // Request latch, returned byte and sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      be_q      <= 2'b00;
      rdata_q   <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= f_addr;
        wdata_q <= f_wdata;
        we_q    <= f_write;
        be_q    <= f_addr[0] ? 2'b10 : 2'b01;
      end
      if (hit_rd)       rdata_q <= byte_sel(cache_word, f_addr[0]);
      else if (rd_load) rdata_q <= byte_sel(mem_rdata, addr_q[0]);
      if (!idle && (f_read || f_write)) overrun_q <= 1'b1;
    end
  end

  assign mem_addr  = addr_q[FADDR_W-1:1];
  assign mem_wdata = {wdata_q, wdata_q};
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign f_rdata   = rdata_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/floppy_sdram_port.md
FLOPPY_SDRAM_PORT -- requirements
Module: floppy_sdram_port

Interface
REQ-001 SHALL have the following ports; clk and reset_n are listed first. Reset is reset_n, asynchronous, active-low. The clock is clk.
- clk  in  1  system clock, 24 MHz
- reset_n  in  1  async active-low reset
- f_addr  in  23  floppy byte address {page[7:0], offset[14:0]}
- f_wdata  in  8  floppy write data
- f_read  in  1  one-cycle read request pulse
- f_write  in  1  one-cycle write request pulse
- f_rdata  out  8  read data returned to floppy
- f_busy  out  1  transaction in progress
- cache_inv  in  1  invalidate read cache (other master wrote SDRAM)
- mem_addr  out  22  SDRAM word address
- mem_wdata  out  16  SDRAM write data
- mem_be  out  2  byte enables, bit0 = low byte
- mem_req  out  1  request to SDRAM arbiter
- mem_we  out  1  1 = write, 0 = read
- mem_ack  in  1  one-cycle request accept
- mem_rdata  in  16  read word
- mem_rvalid  in  1  one-cycle read data valid
- overrun  out  1  sticky: request arrived while busy

Function
REQ-002 SHALL use a state machine with states IDLE, REQ, WAIT_DATA and DONE.
REQ-003 In IDLE, a sampled f_write or f_read SHALL latch the address and data, move to REQ, and assert f_busy from the next cycle.
- If both are asserted in the same cycle, the write wins.
REQ-004 In REQ, the block SHALL hold mem_req=1 with stable mem_addr=f_addr[22:1], mem_we and mem_be until the cycle in which mem_ack=1.
REQ-005 Byte-lane rules SHALL be:
- f_addr[0]=0 selects the low byte, mem_be=01.
- f_addr[0]=1 selects the high byte, mem_be=10.
- mem_wdata = {f_wdata, f_wdata}.
REQ-006 On the mem_ack of a write, the state SHALL move to DONE. On the mem_ack of a read, it SHALL move to WAIT_DATA, or directly to DONE if mem_rvalid=1 in the same cycle.
REQ-007 In WAIT_DATA, on mem_rvalid=1 the selected byte SHALL be loaded into f_rdata and the state SHALL move to DONE.
REQ-008 DONE SHALL last exactly one cycle with f_busy=1, then return to IDLE with f_busy=0.
REQ-009 f_rdata SHALL hold its value until the next read completes; writes do not change it.
REQ-010 Minimum latency SHALL be request pulse at cycle N, mem_req at N+1, f_busy low at N+4 (ack at N+1, rvalid at N+2 for reads).
REQ-011 A f_read or f_write seen while not in IDLE SHALL be dropped and SHALL set overrun=1. overrun holds until reset.
REQ-012 mem_rvalid seen outside WAIT_DATA/REQ SHALL be ignored.

Reset
REQ-013 Reset SHALL be asynchronous and give the following values:
- state=IDLE
- f_busy=0, mem_req=0, mem_we=0, mem_be=00
- f_rdata=8'h00, overrun=0
- cache invalid
REQ-014 Reset asserted mid-transaction SHALL abort immediately and drop mem_req in the same cycle. No retry is made after release.

Configuration
REQ-015 Macro FLOPPY_SDRAM_RDCACHE_EN SHALL, when defined, add a one-word read cache: a 16-bit word, a 22-bit tag and a valid bit.
REQ-016 With the cache:
- A read whose f_addr[22:1] matches a valid tag SHALL skip the SDRAM: no mem_req, IDLE to DONE, f_rdata updated, f_busy high for exactly 1 cycle.
- A miss SHALL fill the cache on mem_rvalid.
- A write to the cached word SHALL update the cached byte (write-through) and still issue to SDRAM.
- cache_inv=1 SHALL clear valid, with priority over a same-cycle fill.
REQ-017 Without the macro, every read SHALL go to SDRAM and cache_inv SHALL be ignored.

Structure
REQ-018 A shared package floppy_pkg SHALL hold:
- state encodings
- widths: FADDR_W=23, MADDR_W=22, MDATA_W=16
REQ-019 The cache SHALL be one sub-module, floppy_sdram_rdcache, instantiated only when FLOPPY_SDRAM_RDCACHE_EN is defined. All other logic stays flat.

Verification
REQ-020 Write f_addr=23'h012345, f_wdata=8'hA5, ack after 3 cycles -> mem_addr=22'h0091A2, mem_be=10, mem_wdata=16'hA5A5, mem_we=1; f_busy falls 1 cycle after DONE.
REQ-021 Read f_addr=23'h000100, ack with rvalid in the same cycle, mem_rdata=16'hBEEF -> f_rdata=8'hEF; f_busy total 3 cycles.
REQ-022 f_read and f_write pulsed together at addr 23'h000001 -> write only issued, mem_we=1, mem_be=10.
REQ-023 f_read pulsed while in WAIT_DATA -> no second mem_req, overrun=1 until reset_n low.
REQ-024 Macro on: read 23'h000200 (miss, rdata 16'h1234), then read 23'h000201 -> no mem_req, f_rdata=8'h12, f_busy 1 cycle. Pulse cache_inv, then read 23'h000200 again -> mem_req issued.
REQ-025 reset_n low during REQ -> mem_req=0 and f_busy=0 asynchronously; after release, the block idles with no request.
